// File: rtl/issue_scheduler.sv
// In-order single-issue gate between ID and EXE: per-GPR write scoreboard plus multi-cycle divider sequencer.
// issue_go is combinational in the ID cycle; stalls hold ID whenever EXE refuses, a hazard is open or the divider is taken.
module issue_scheduler #(
   parameter int DIV_LAT = 8,
   parameter int CNT_W   = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        id_valid,
   input  logic        id_src1_en,
   input  logic [4:0]  id_src1_addr,
   input  logic        id_src2_en,
   input  logic [4:0]  id_src2_addr,
   input  logic        id_dst_we,
   input  logic [4:0]  id_dst_addr,
   input  logic        id_is_div,
   input  logic        exe_allowin,
   input  logic        byp0_valid,
   input  logic [4:0]  byp0_addr,
   input  logic        byp1_valid,
   input  logic [4:0]  byp1_addr,
   input  logic        wb_valid,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic        flush,
   input  logic        div_ack,
   output logic        issue_go,
   output logic        id_stall,
   output logic        div_start,
   output logic        div_busy,
   output logic        div_done,
   output logic [31:0] sb_pending,
   output logic        sb_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   div_state_t       state;
   logic [4:0]       lat_cnt;
   logic [CNT_W-1:0] cnt [32];

   logic        wb_ret;
   logic        hit1, hit2;
   logic        src1_ok, src2_ok, dst_ok, div_ok;
   logic [31:0] inc_vec, dec_vec;

   assign wb_ret = wb_valid & wb_we;

   assign hit1 = (byp0_valid && byp0_addr == id_src1_addr) ||
                 (byp1_valid && byp1_addr == id_src1_addr) ||
                 (wb_ret     && wb_addr   == id_src1_addr);
   assign hit2 = (byp0_valid && byp0_addr == id_src2_addr) ||
                 (byp1_valid && byp1_addr == id_src2_addr) ||
                 (wb_ret     && wb_addr   == id_src2_addr);

   // With two or more writers in flight a bypass hit may belong to the older one, so only cnt==1 may forward.
   assign src1_ok = !id_src1_en || id_src1_addr == 5'd0 || cnt[id_src1_addr] == '0 ||
                    (cnt[id_src1_addr] == CNT_ONE && hit1);
   assign src2_ok = !id_src2_en || id_src2_addr == 5'd0 || cnt[id_src2_addr] == '0 ||
                    (cnt[id_src2_addr] == CNT_ONE && hit2);
   assign dst_ok  = !id_dst_we || id_dst_addr == 5'd0 || cnt[id_dst_addr] != CNT_MAX;
   assign div_ok  = !id_is_div || state == IDLE;

   assign issue_go  = resetn & id_valid & exe_allowin & ~flush &
                      src1_ok & src2_ok & dst_ok & div_ok;
   assign id_stall  = id_valid & ~issue_go;
   assign div_start = issue_go & id_is_div;
   assign div_busy  = (state != IDLE);
   assign div_done  = resetn & (state == DONE);

   assign inc_vec = (issue_go && id_dst_we) ? ((32'd1 << id_dst_addr) & ~32'd1) : 32'd0;
   assign dec_vec = wb_ret ? ((32'd1 << wb_addr) & ~32'd1) : 32'd0;

   always_comb begin
      sb_pending = '0;
      for (int r = 0; r < 32; r++) begin
         sb_pending[r] = (cnt[r] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int r = 0; r < 32; r++) begin
            cnt[r] <= '0;
         end
         state        <= IDLE;
         lat_cnt      <= '0;
         sb_underflow <= 1'b0;
      end else if (flush) begin
         for (int r = 0; r < 32; r++) begin
            cnt[r] <= '0;
         end
         state   <= IDLE;
         lat_cnt <= '0;
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < 32; r++) begin
            if (inc_vec[r] && !dec_vec[r]) begin
               cnt[r] <= cnt[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0) begin
               cnt[r] <= cnt[r] - CNT_ONE;
            end
         end
         if ((dec_vec & ~sb_pending) != 32'd0) begin
            sb_underflow <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (div_start) begin
                  state   <= BUSY;
                  lat_cnt <= 5'(DIV_LAT - 1);
               end
            end
            BUSY: begin
               lat_cnt <= lat_cnt - 5'd1;
               if (lat_cnt == 5'd1) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (div_ack) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed-vector bench for issue_scheduler (DIV_LAT=8, CNT_W=2) with hand-computed expectations.
module tb_issue_scheduler;

   logic        clk;
   logic        resetn;
   logic        id_valid;
   logic        id_src1_en, id_src2_en;
   logic [4:0]  id_src1_addr, id_src2_addr;
   logic        id_dst_we;
   logic [4:0]  id_dst_addr;
   logic        id_is_div;
   logic        exe_allowin;
   logic        byp0_valid, byp1_valid;
   logic [4:0]  byp0_addr, byp1_addr;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_addr;
   logic        flush;
   logic        div_ack;
   logic        issue_go, id_stall, div_start, div_busy, div_done, sb_underflow;
   logic [31:0] sb_pending;

   int n_vec = 0;
   int n_err = 0;

   issue_scheduler #(.DIV_LAT(8), .CNT_W(2)) dut (
      .clk(clk), .resetn(resetn),
      .id_valid(id_valid),
      .id_src1_en(id_src1_en), .id_src1_addr(id_src1_addr),
      .id_src2_en(id_src2_en), .id_src2_addr(id_src2_addr),
      .id_dst_we(id_dst_we), .id_dst_addr(id_dst_addr),
      .id_is_div(id_is_div), .exe_allowin(exe_allowin),
      .byp0_valid(byp0_valid), .byp0_addr(byp0_addr),
      .byp1_valid(byp1_valid), .byp1_addr(byp1_addr),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
      .flush(flush), .div_ack(div_ack),
      .issue_go(issue_go), .id_stall(id_stall),
      .div_start(div_start), .div_busy(div_busy), .div_done(div_done),
      .sb_pending(sb_pending), .sb_underflow(sb_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clr_in();
      id_valid = 0; id_src1_en = 0; id_src2_en = 0;
      id_src1_addr = 0; id_src2_addr = 0;
      id_dst_we = 0; id_dst_addr = 0; id_is_div = 0;
      exe_allowin = 1;
      byp0_valid = 0; byp0_addr = 0; byp1_valid = 0; byp1_addr = 0;
      wb_valid = 0; wb_we = 0; wb_addr = 0;
      flush = 0; div_ack = 0;
   endtask

   task automatic id_set(input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] dst, input logic div);
      id_valid = 1; id_src1_en = 1; id_src2_en = 1;
      id_src1_addr = s1; id_src2_addr = s2;
      id_dst_we = 1; id_dst_addr = dst; id_is_div = div;
   endtask

   task automatic retire(input logic [4:0] a);
      wb_valid = 1; wb_we = 1; wb_addr = a;
   endtask

   initial begin
      clr_in();
      resetn = 0;
      id_set(1, 2, 3, 0);
      settle();
      chk("rst_go", issue_go, 0);
      tick(); tick();
      chk("rst_pend", sb_pending, 0);
      chk("rst_busy", div_busy, 0);
      chk("rst_done", div_done, 0);
      chk("rst_uflow", sb_underflow, 0);
      resetn = 1;
      clr_in();

      // r0 is never tracked
      id_set(0, 0, 0, 0); settle();
      chk("r0_go", issue_go, 1);
      tick(); clr_in(); retire(0); settle();
      chk("r0_pend", sb_pending, 0);
      tick(); clr_in(); settle();
      chk("r0_uflow", sb_underflow, 0);

      // back-to-back independent adds
      id_set(3, 4, 1, 0); settle();
      chk("b2b_go0", issue_go, 1);
      tick(); id_set(3, 4, 2, 0); settle();
      chk("b2b_go1", issue_go, 1);
      tick(); clr_in(); settle();
      chk("b2b_pend", sb_pending, 32'h6);
      retire(1); tick(); retire(2); tick(); clr_in(); settle();
      chk("b2b_clean", sb_pending, 0);

      // dependent add with EXE bypass
      id_set(3, 4, 5, 0); tick();
      id_set(5, 0, 6, 0); byp0_valid = 1; byp0_addr = 5; settle();
      chk("byp_go", issue_go, 1);
      tick(); clr_in(); retire(5); tick(); retire(6); tick(); clr_in();

      // dependent add without bypass waits for WB
      id_set(3, 4, 5, 0); tick();
      id_set(5, 0, 6, 0); settle();
      chk("nobyp_go", issue_go, 0);
      chk("nobyp_stall", id_stall, 1);
      tick(); settle();
      chk("nobyp_go2", issue_go, 0);
      retire(5); settle();
      chk("wb_go", issue_go, 1);
      tick(); clr_in(); settle();
      chk("wb_pend", sb_pending, 32'h40);
      retire(6); tick(); clr_in();

      // saturate r7
      for (int k = 0; k < 3; k++) begin
         id_set(0, 0, 7, 0); settle();
         chk("r7_go", issue_go, 1);
         tick();
      end
      settle();
      chk("r7_pend", sb_pending, 32'h80);
      chk("r7_full", issue_go, 0);
      id_set(7, 0, 0, 0); byp0_valid = 1; byp0_addr = 7; settle();
      chk("r7_byp", issue_go, 0);
      clr_in();
      for (int k = 0; k < 3; k++) begin
         retire(7); tick();
      end
      clr_in(); settle();
      chk("r7_clean", sb_pending, 0);

      // divider sequencing, T = this cycle
      id_set(0, 0, 8, 1); settle();
      chk("div_go", issue_go, 1);
      chk("div_start", div_start, 1);
      tick();
      id_set(0, 0, 11, 1); settle();
      chk("div_busy", div_busy, 1);
      chk("div_start_once", div_start, 0);
      for (int k = 1; k < 8; k++) begin
         chk("div_done_early", div_done, 0);
         chk("div2_stall", issue_go, 0);
         tick(); settle();
      end
      chk("div_done_rise", div_done, 1);
      tick(); settle();
      chk("div_done_hold", div_done, 1);
      div_ack = 1; settle();
      chk("ack_cycle_go", issue_go, 0);
      tick(); div_ack = 0; settle();
      chk("div_idle", div_busy, 0);
      chk("div_done_drop", div_done, 0);
      chk("div2_go", issue_go, 1);
      chk("div2_start", div_start, 1);
      tick();

      // non-div issue while divider busy, then flush
      id_set(0, 0, 3, 0); settle();
      chk("nd_busy_go0", issue_go, 1);
      tick(); settle();
      chk("nd_busy_go1", issue_go, 1);
      tick(); clr_in(); settle();
      chk("pre_flush_pend", sb_pending, 32'h908);
      chk("pre_flush_busy", div_busy, 1);
      id_set(0, 0, 4, 0); flush = 1; settle();
      chk("flush_go", issue_go, 0);
      tick(); clr_in(); settle();
      chk("flush_pend", sb_pending, 0);
      chk("flush_busy", div_busy, 0);

      // same-cycle issue and retire on r9, then underflow on r10
      id_set(0, 0, 9, 0); tick();
      id_set(0, 0, 9, 0); retire(9); settle();
      chk("sim_go", issue_go, 1);
      tick(); clr_in(); settle();
      chk("sim_pend", sb_pending, 32'h200);
      chk("uflow_clear", sb_underflow, 0);
      retire(10); tick(); clr_in(); settle();
      chk("uflow_set", sb_underflow, 1);
      tick(); settle();
      chk("uflow_sticky", sb_underflow, 1);
      chk("uflow_pend", sb_pending, 32'h200);

      // reset in the middle of a divide
      id_set(0, 0, 12, 1); settle();
      chk("rdiv_go", issue_go, 1);
      tick(); clr_in(); settle();
      chk("rdiv_busy", div_busy, 1);
      resetn = 0; id_set(0, 0, 13, 0); settle();
      chk("rst2_go", issue_go, 0);
      tick(); resetn = 1; clr_in(); settle();
      chk("rst2_pend", sb_pending, 0);
      chk("rst2_busy", div_busy, 0);
      chk("rst2_uflow", sb_underflow, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- In-order single-issue scheduler between ID and EXE.
- Keeps a per-register scoreboard of in-flight writes and decides each cycle whether the ID instruction may issue.
- Source operands are legal if no write is pending, or if the single pending producer's value is on a bypass port this cycle.
- Owns the multi-cycle divider: serialises access and sequences start, busy and done.

Parameters:
- DIV_LAT, 8, divider latency in cycles from div_start to result valid; legal range 2..31.
- CNT_W, 2, scoreboard counter width; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_src1_en / id_src2_en  in  1  source reads a GPR
- id_src1_addr / id_src2_addr  in  5  source GPR number
- id_dst_we  in  1  instruction writes a GPR
- id_dst_addr  in  5  destination GPR
- id_is_div  in  1  instruction uses the divider
- exe_allowin  in  1  EXE can accept an instruction this cycle
- byp0_valid, byp0_addr  in  1,5  EXE result valid for bypass
- byp1_valid, byp1_addr  in  1,5  MEM result valid for bypass
- wb_valid, wb_we, wb_addr  in  1,1,5  WB retiring a GPR write this cycle
- flush  in  1  pipeline squash (exception/ertn)
- div_ack  in  1  WB has taken the divider result
- issue_go  out  1  instruction issues this cycle (combinational)
- id_stall  out  1  id_valid & ~issue_go
- div_start  out  1  one-cycle start pulse to divider
- div_busy  out  1  divider FSM not IDLE
- div_done  out  1  divider result valid, held until div_ack
- sb_pending  out  32  bit r = (cnt[r]!=0)
- sb_underflow  out  1  sticky: retire seen with cnt==0

Behaviour:
- Reset (resetn=0 at a clk edge): all cnt[r] to 0, FSM to IDLE, latency counter to 0, sb_underflow to 0. While resetn=0, issue_go, div_start and div_done are 0.
- Register 0 is never tracked: cnt[0] is always 0 and r0 sources are always ready.
- src_ok(i) = ~en | addr==0 | cnt[addr]==0 | (cnt[addr]==1 & hit).
  - hit = (byp0_valid & byp0_addr==addr) | (byp1_valid & byp1_addr==addr) | (wb_valid & wb_we & wb_addr==addr).
  - cnt>=2 always stalls: a bypass could come from the older writer.
- dst_ok = ~id_dst_we | id_dst_addr==0 | cnt[id_dst_addr] != max.
- div_ok = ~id_is_div | state==IDLE.
- issue_go = resetn & id_valid & exe_allowin & ~flush & src_ok(1) & src_ok(2) & dst_ok & div_ok.
- Scoreboard update per register r, per cycle:
  - +1 if issue_go & id_dst_we & id_dst_addr==r (r != 0).
  - -1 if wb_valid & wb_we & wb_addr==r.
  - Simultaneous +1 and -1 leaves cnt unchanged.
  - A -1 when cnt==0 leaves cnt at 0 and sets sb_underflow.
- flush has priority over everything: at the edge all cnt clear to 0, FSM goes to IDLE and no issue occurs. The pipeline squashes every younger in-flight write, and WB ignores writes from squashed instructions.
- Divider FSM:
  - IDLE: on issue_go & id_is_div, div_start=1 that cycle; next state BUSY, counter=DIV_LAT-1.
  - BUSY: counter decrements each cycle; when counter==1, next state DONE.
  - DONE: div_done=1; on div_ack go to IDLE. A new div may issue in the cycle after returning to IDLE, not in the ack cycle.
  - Result valid exactly DIV_LAT cycles after the div_start cycle.
  - div_busy = (state != IDLE).
  - flush in any state forces IDLE next cycle, and div_done drops next cycle.
- A non-div instruction can issue while the divider is BUSY or DONE. Its hazards on the div destination are caught by the scoreboard.
- div_ack outside DONE is ignored.
- All state is updated on the rising clk edge only.

Test Plan:
- Back-to-back independent adds (dst r1, r2; srcs r3, r4, exe_allowin=1) -> issue_go=1 both cycles; sb_pending=0x6 after the second.
- Issue add r5 then add using r5 with byp0_valid=1, byp0_addr=5 -> the second issues the next cycle. The same case with byp0_valid=0 -> stalls until wb retires r5 (cnt 1 to 0), then issues.
- Three writes to r7 with no retire -> cnt[7]=3; a fourth writer of r7 stalls. A reader of r7 with bypass hit still stalls (cnt>=2).
- DIV_LAT=8: div issues at cycle T -> div_start at T, div_done rises at T+8, holds until div_ack; a second div stalls until the cycle after the ack.
- Same-cycle issue writing r9 and wb retiring r9 at cnt[9]=1 -> cnt stays 1. A wb retire on r10 with cnt 0 -> sb_underflow=1 and stays set.
- flush mid-BUSY with cnt[3]=2 -> next cycle all sb_pending=0, div_busy=0, issue_go=0 during the flush cycle. resetn=0 for one edge mid-op -> same cleared state.
